// File: rtl/uart_pkg.sv
// Shared UART constants and types; the receive FIFO takes its defaults from here.
package uart_pkg;

   localparam int unsigned RX_FIFO_DATA_WIDTH = 8;
   localparam int unsigned RX_FIFO_DEPTH      = 16;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic parity_err;
      logic frame_err;
   } rx_fifo_flags_t;

   // Set wins over clear so an event coincident with a clear is never lost.
   function automatic logic sticky_next(input logic set, input logic q, input logic clr);
      return set | (q & ~clr);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, registered synchronous read, no reset.
module fifo_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // Read returns the old word when both ports hit the same address.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/rx_fifo.sv
// UART receive FIFO: edge-detected write strobe, latency-1 pop, occupancy and sticky error status.
module rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RX_FIFO_DATA_WIDTH,
   parameter int unsigned DEPTH      = RX_FIFO_DEPTH
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic [DATA_WIDTH-1:0]    WR_DATA,
   input  logic                     WR_STROBE,
   input  logic                     PARITY_ERR_IN,
   input  logic                     FRAME_ERR_IN,
   input  logic                     RD_EN,
   input  logic                     CLR_ERR,
   output logic [DATA_WIDTH-1:0]    RD_DATA,
   output logic                     RD_VALID,
   output logic                     EMPTY,
   output logic                     FULL,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic                     OVERFLOW,
   output logic                     UNDERFLOW,
   output logic                     PARITY_ERR,
   output logic                     FRAME_ERR
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rd_valid_q, rd_valid_d;
   logic            rd_loaded_q, rd_loaded_d;
   logic            strobe_q, strobe_d;
   logic            perr_in_q, perr_in_d;
   logic            ferr_in_q, ferr_in_d;
   rx_fifo_flags_t  flags_q, flags_d;

   logic            empty, full;
   logic            wr_req, wr_acc, pop;
   logic [DATA_WIDTH-1:0] mem_rdata;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   always_comb begin
      wr_req = WR_STROBE & ~strobe_q;
      pop    = RD_EN & ~empty;
      // When full, a same-cycle pop frees the slot the write lands in.
      wr_acc = wr_req & (~full | RD_EN);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

      count_d     = count_q + CW'(wr_acc) - CW'(pop);
      rd_valid_d  = pop;
      rd_loaded_d = rd_loaded_q | pop;

      strobe_d    = WR_STROBE;
      perr_in_d   = PARITY_ERR_IN;
      ferr_in_d   = FRAME_ERR_IN;

      flags_d.overflow   = sticky_next(wr_req & full & ~RD_EN, flags_q.overflow, CLR_ERR);
      flags_d.underflow  = sticky_next(RD_EN & empty, flags_q.underflow, CLR_ERR);
      flags_d.parity_err = sticky_next(PARITY_ERR_IN & ~perr_in_q, flags_q.parity_err, CLR_ERR);
      flags_d.frame_err  = sticky_next(FRAME_ERR_IN & ~ferr_in_q, flags_q.frame_err, CLR_ERR);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rd_valid_q  <= 1'b0;
         rd_loaded_q <= 1'b0;
         strobe_q    <= 1'b0;
         perr_in_q   <= 1'b0;
         ferr_in_q   <= 1'b0;
         flags_q     <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rd_valid_q  <= rd_valid_d;
         rd_loaded_q <= rd_loaded_d;
         strobe_q    <= strobe_d;
         perr_in_q   <= perr_in_d;
         ferr_in_q   <= ferr_in_d;
         flags_q     <= flags_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk     (CLK),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (WR_DATA),
      .rd_en   (pop),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rdata)
   );

   // Storage has no reset; mask its output until a pop has loaded it since reset.
   assign RD_DATA    = rd_loaded_q ? mem_rdata : '0;
   assign RD_VALID   = rd_valid_q;
   assign EMPTY      = empty;
   assign FULL       = full;
   assign COUNT      = count_q;
   assign OVERFLOW   = flags_q.overflow;
   assign UNDERFLOW  = flags_q.underflow;
   assign PARITY_ERR = flags_q.parity_err;
   assign FRAME_ERR  = flags_q.frame_err;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed bench for rx_fifo: per-cycle vector table plus hand sequences for fill, overflow and reset.
module tb_rx_fifo;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic [7:0] WR_DATA;
   logic       WR_STROBE, PARITY_ERR_IN, FRAME_ERR_IN, RD_EN, CLR_ERR;
   logic [7:0] RD_DATA;
   logic       RD_VALID, EMPTY, FULL;
   logic [4:0] COUNT;
   logic       OVERFLOW, UNDERFLOW, PARITY_ERR, FRAME_ERR;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   rx_fifo dut (
      .CLK           (CLK),
      .RESET_N       (RESET_N),
      .WR_DATA       (WR_DATA),
      .WR_STROBE     (WR_STROBE),
      .PARITY_ERR_IN (PARITY_ERR_IN),
      .FRAME_ERR_IN  (FRAME_ERR_IN),
      .RD_EN         (RD_EN),
      .CLR_ERR       (CLR_ERR),
      .RD_DATA       (RD_DATA),
      .RD_VALID      (RD_VALID),
      .EMPTY         (EMPTY),
      .FULL          (FULL),
      .COUNT         (COUNT),
      .OVERFLOW      (OVERFLOW),
      .UNDERFLOW     (UNDERFLOW),
      .PARITY_ERR    (PARITY_ERR),
      .FRAME_ERR     (FRAME_ERR)
   );

   typedef struct {
      logic       s;
      logic [7:0] d;
      logic       r, pe, fe, c;
      logic       v;
      logic [7:0] rd;
      int         cnt;
      logic       ovf, udf, pef, fef;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic s, logic [7:0] d, logic r, logic pe, logic fe, logic c,
                               logic v, logic [7:0] rd, int cnt,
                               logic ovf, logic udf, logic pef, logic fef);
      vec_t t;
      t.s = s; t.d = d; t.r = r; t.pe = pe; t.fe = fe; t.c = c;
      t.v = v; t.rd = rd; t.cnt = cnt;
      t.ovf = ovf; t.udf = udf; t.pef = pef; t.fef = fef;
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [7:0] rd, input int cnt,
                          input logic ovf, input logic udf, input logic pef, input logic fef);
      chk({tag, ".rd_valid"},  int'(RD_VALID), int'(v));
      chk({tag, ".rd_data"},   int'(RD_DATA), int'(rd));
      chk({tag, ".count"},     int'(COUNT), cnt);
      chk({tag, ".empty"},     int'(EMPTY), int'(cnt == 0));
      chk({tag, ".full"},      int'(FULL), int'(cnt == 16));
      chk({tag, ".overflow"},  int'(OVERFLOW), int'(ovf));
      chk({tag, ".underflow"}, int'(UNDERFLOW), int'(udf));
      chk({tag, ".parity"},    int'(PARITY_ERR), int'(pef));
      chk({tag, ".frame"},     int'(FRAME_ERR), int'(fef));
   endtask

   // Drive one cycle's inputs just after an edge, then settle past the next edge.
   task automatic step(input logic s, input logic [7:0] d, input logic r,
                       input logic pe, input logic fe, input logic c);
      WR_STROBE = s; WR_DATA = d; RD_EN = r;
      PARITY_ERR_IN = pe; FRAME_ERR_IN = fe; CLR_ERR = c;
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_write(input logic [7:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      RESET_N = 1'b1;
      WR_STROBE = 0; WR_DATA = 0; RD_EN = 0;
      PARITY_ERR_IN = 0; FRAME_ERR_IN = 0; CLR_ERR = 0;
      #3 RESET_N = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      chk_all("reset", 0, 8'h00, 0, 0, 0, 0, 0);
      RESET_N = 1'b1;

      //        s  d      r  pe fe c    v  rd     cnt ovf udf pef fef
      vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h11, 0, 0, 0, 0,  0, 8'h00, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0,  0, 8'h00, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h22, 0, 0, 0, 0,  0, 8'h00, 2, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0,  0, 8'h00, 3, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h11, 2, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h22, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h33, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 8'h33, 0, 0, 0, 0, 0));
      // strobe held high five cycles: one entry
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 0,  0, 8'h33, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 8'hA5, 0, 0, 0, 0, 0));
      // underflow, frame error vs clear, parity edge detect
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 8'hA5, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1,  0, 8'hA5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 8'hA5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0,  0, 8'hA5, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 1,  0, 8'hA5, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  0, 8'hA5, 0, 0, 0, 0, 0));
      // read while empty alongside a write: write still lands
      vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 0,  0, 8'hA5, 1, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 8'h5A, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 8'h5A, 0, 0, 0, 0, 0));

      foreach (vecs[i]) begin
         step(vecs[i].s, vecs[i].d, vecs[i].r, vecs[i].pe, vecs[i].fe, vecs[i].c);
         chk_all($sformatf("vec%0d", i), vecs[i].v, vecs[i].rd, vecs[i].cnt,
                 vecs[i].ovf, vecs[i].udf, vecs[i].pef, vecs[i].fef);
      end

      // fill to full, then overflow
      for (int i = 0; i < 16; i++) pulse_write(8'(i));
      chk_all("fill", 0, 8'h5A, 16, 0, 0, 0, 0);
      pulse_write(8'hFF);
      chk_all("overflow", 0, 8'h5A, 16, 1, 0, 0, 0);

      // write while full with a same-cycle pop
      step(1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all("full_wr_rd", 1, 8'h00, 16, 1, 0, 0, 0);
      for (int i = 1; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
         chk_all($sformatf("drain%0d", i), 1, 8'(i), 16 - i, 1, 0, 0, 0);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all("drain_last", 1, 8'h80, 0, 1, 0, 0, 0);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_all("drain_idle", 0, 8'h80, 0, 1, 0, 0, 0);

      // mid-operation reset with 8 entries and overflow still set
      for (int i = 0; i < 8; i++) pulse_write(8'h40 + 8'(i));
      chk_all("pre_reset", 0, 8'h80, 8, 1, 0, 0, 0);
      RESET_N = 1'b0;
      WR_STROBE = 1'b0;
      #1;
      chk_all("mid_reset", 0, 8'h00, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk_all("reset_hold", 0, 8'h00, 0, 0, 0, 0, 0);
      RESET_N = 1'b1;
      // strobe already high at release still counts as a rising edge
      step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_all("post_reset_wr", 0, 8'h00, 1, 0, 0, 0, 0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk_all("post_reset_rd", 1, 8'hC3, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
